// File: rtl/proc_memory_pkg.sv
// Shared definitions for the processor memory responder: FSM state encoding and default width.
package proc_memory_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_CLEAR = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10
    } state_t;

endpackage

// File: rtl/proc_memory_mem_array.sv
// DEPTH x n storage with two asynchronous read ports and one synchronous write port.
module mem_array #(
    parameter int n     = 8,
    parameter int DEPTH = 1 << n
) (
    input  logic         clk,
    input  logic         we,
    input  logic [n-1:0] waddr,
    input  logic [n-1:0] wdata,
    input  logic [n-1:0] raddr1,
    output logic [n-1:0] rdata1,
    input  logic [n-1:0] raddr2,
    output logic [n-1:0] rdata2
);

    logic [n-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the owner clears the array after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/proc_memory.sv
// Processor memory responder: clears the array, loads a program stream while holding the core
// in reset, then serves the core's write port and two combinational read ports.
module proc_memory
    import proc_memory_pkg::*;
#(
    parameter int n      = N_DEFAULT,
    parameter int DEPTH  = 1 << n,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] mem_wr_data,
    input  logic [n-1:0] mem_wr_addr,
    input  logic         mem_wr_en,
    input  logic [n-1:0] mem_rd_addr1,
    output logic [n-1:0] mem_rd_data1,
    input  logic [n-1:0] mem_rd_addr2,
    output logic [n-1:0] mem_rd_data2,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_data,
    input  logic         ld_last,
    output logic         ld_ready,
    output logic         cpu_reset,
    output logic [n:0]   ld_count,
    output logic [n-1:0] wr_count
);

    localparam logic [n-1:0] LAST_ADDR = n'(DEPTH - 1);

    state_t       state;
    state_t       next_state;
    logic [n-1:0] clr_ptr;
    logic [n-1:0] ld_ptr;
    logic         ld_accept;
    logic         core_write;
    logic         mem_we;
    logic [n-1:0] mem_waddr;
    logic [n-1:0] mem_wdata;
    logic [n-1:0] arr_rd_data1;
    logic [n-1:0] arr_rd_data2;

    assign ld_ready   = (state == S_LOAD);
    assign ld_accept  = ld_valid && ld_ready;
    assign core_write = (state == S_RUN) && mem_wr_en;

    always_comb begin
        next_state = state;
        unique case (state)
            S_CLEAR: if (clr_ptr == LAST_ADDR) next_state = S_LOAD;
            // The word at the top address ends the load so the pointer never wraps.
            S_LOAD:  if (ld_accept && (ld_last || ld_ptr == LAST_ADDR)) next_state = S_RUN;
            S_RUN:   next_state = S_RUN;
            default: next_state = S_CLEAR;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
            end
            S_LOAD: begin
                mem_we    = ld_accept;
                mem_waddr = ld_ptr;
                mem_wdata = ld_data;
            end
            S_RUN: begin
                mem_we    = mem_wr_en;
                mem_waddr = mem_wr_addr;
                mem_wdata = mem_wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR;
            clr_ptr   <= '0;
            ld_ptr    <= '0;
            ld_count  <= '0;
            wr_count  <= '0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != S_RUN);
            if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + n'(1);
            end
            if (ld_accept) begin
                if (ld_ptr != LAST_ADDR) begin
                    ld_ptr <= ld_ptr + n'(1);
                end
                ld_count <= ld_count + (n+1)'(1);
            end
            if (core_write && wr_count != '1) begin
                wr_count <= wr_count + n'(1);
            end
        end
    end

    mem_array #(
        .n     (n),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr1 (mem_rd_addr1),
        .rdata1 (arr_rd_data1),
        .raddr2 (mem_rd_addr2),
        .rdata2 (arr_rd_data2)
    );

    // Same-cycle core writes are forwarded to either read port independently.
    assign mem_rd_data1 = (BYPASS != 0 && core_write && mem_wr_addr == mem_rd_addr1)
                          ? mem_wr_data : arr_rd_data1;
    assign mem_rd_data2 = (BYPASS != 0 && core_write && mem_wr_addr == mem_rd_addr2)
                          ? mem_wr_data : arr_rd_data2;

endmodule
